// File: rtl/seven_seg_reader.sv
// seven_seg_reader
//   Watches a two-digit multiplexed seven-segment display bus and recovers the
//   hex value shown on each digit. A {digit_en, seven_seg} pattern is accepted
//   only after it has been captured STABLE_CYCLES times in a row. Each stable
//   run is committed exactly once.
//
//   Optional feature: define SEVEN_SEG_BLANK_DETECT_EN to treat the all-off
//   code 1111111 as a blank digit. A blank clears that digit's valid bit
//   silently. Without the macro, the all-off code is an illegal pattern.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous active-low reset
//   seven_seg   in   [6:0] active-low segments, [6]=g ... [0]=a
//   digit_en    in   [1:0] active-high digit select (01 = digit0, 10 = digit1)
//   digit0      out  [3:0] last accepted hex value of digit0
//   digit1      out  [3:0] last accepted hex value of digit1
//   valid       out  [1:0] valid[i] set while digit i holds an accepted legal value
//   update      out  one-cycle pulse when a digit is written
//   bad_pattern out  one-cycle pulse when a stable pattern is illegal
module seven_seg_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seven_seg,
  input  logic [1:0] digit_en,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [1:0] valid,
  output logic       update,
  output logic       bad_pattern
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

`ifdef SEVEN_SEG_BLANK_DETECT_EN
  localparam logic BLANK_DETECT = 1'b1;
`else
  localparam logic BLANK_DETECT = 1'b0;
`endif

  typedef enum logic {TRACK, LOCKED} state_t;

  state_t     state;
  state_t     state_next;
  logic [8:0] samp;
  logic [8:0] incoming;
  logic [7:0] cnt;
  logic       same;
  logic       commit;
  logic       dec_legal;
  logic [3:0] dec_value;
  logic       is_blank;
  logic       one_hot;
  logic       sel;

  assign incoming = {digit_en, seven_seg};
  assign same     = (incoming == samp);
  assign one_hot  = (samp[8:7] == 2'b01) || (samp[8:7] == 2'b10);
  assign sel      = samp[8];
  assign is_blank = BLANK_DETECT && (samp[6:0] == 7'b1111111);

  // Decode the captured segment pattern into its hex nibble.
  always_comb begin
    dec_legal = 1'b1;
    dec_value = 4'h0;
    case (samp[6:0])
      7'b1000000: dec_value = 4'h0;
      7'b1111001: dec_value = 4'h1;
      7'b0100100: dec_value = 4'h2;
      7'b0110000: dec_value = 4'h3;
      7'b0011001: dec_value = 4'h4;
      7'b0010010: dec_value = 4'h5;
      7'b0000010: dec_value = 4'h6;
      7'b1111000: dec_value = 4'h7;
      7'b0000000: dec_value = 4'h8;
      7'b0011000: dec_value = 4'h9;
      7'b0001000: dec_value = 4'hA;
      7'b0000011: dec_value = 4'hB;
      7'b1000110: dec_value = 4'hC;
      7'b0100001: dec_value = 4'hD;
      7'b0000110: dec_value = 4'hE;
      7'b0001110: dec_value = 4'hF;
      default:    dec_legal = 1'b0;
    endcase
  end

  // A commit always uses the old samp. When new inputs arrive on the commit
  // edge, the machine stays in TRACK. That way, the run that has just
  // started still gets its own commit.
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      TRACK: begin
        if (cnt == STABLE_MAX) begin
          commit     = 1'b1;
          state_next = same ? LOCKED : TRACK;
        end
      end
      LOCKED: begin
        if (!same) state_next = TRACK;
      end
      default: state_next = TRACK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= TRACK;
    else        state <= state_next;
  end

  // Sample and run counter. A changed input restarts the run at 1, and the
  // count saturates so that a long, steady display cannot wrap it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      samp <= '0;
      cnt  <= '0;
    end else begin
      samp <= incoming;
      if (!same)                    cnt <= 8'd1;
      else if (cnt >= STABLE_MAX)   cnt <= STABLE_MAX;
      else                          cnt <= cnt + 8'd1;
    end
  end

  // Output registers. The pulses default low, so each one lasts exactly one
  // cycle. A commit with no digit selected (00 or 11) is ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      digit0      <= 4'h0;
      digit1      <= 4'h0;
      valid       <= 2'b00;
      update      <= 1'b0;
      bad_pattern <= 1'b0;
    end else begin
      update      <= 1'b0;
      bad_pattern <= 1'b0;
      if (commit && one_hot) begin
        if (is_blank) begin
          valid[sel] <= 1'b0;
        end else if (dec_legal) begin
          if (sel) digit1 <= dec_value;
          else     digit0 <= dec_value;
          valid[sel] <= 1'b1;
          update     <= 1'b1;
        end else begin
          valid[sel]  <= 1'b0;
          bad_pattern <= 1'b1;
        end
      end
    end
  end

endmodule
